// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control for the ID/EXE boundary.
// Tracks in-flight destinations in EXE/MEM/WB shadow slots.
module hazard_forward_unit #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 forwarding_en,
    input  logic                 flush,
    input  logic [3:0]           id_src1,
    input  logic [3:0]           id_src2,
    input  logic                 id_has_src1,
    input  logic                 id_has_src2,
    input  logic                 id_wb_en,
    input  logic                 id_mem_r_en,
    input  logic [3:0]           id_wb_reg_dest,
    output logic                 hazard_stall,
    output logic [1:0]           sel_src1,
    output logic [1:0]           sel_src2,
    output logic [CNT_WIDTH-1:0] stall_count
);

    logic                 r_exe_wb_en;
    logic                 r_exe_mem_r_en;
    logic [3:0]           r_exe_dest;
    logic [3:0]           r_exe_src1;
    logic [3:0]           r_exe_src2;
    logic                 r_exe_has_src1;
    logic                 r_exe_has_src2;
    logic                 r_mem_wb_en;
    logic                 r_mem_mem_r_en;
    logic [3:0]           r_mem_dest;
    logic                 r_wb_wb_en;
    logic [3:0]           r_wb_dest;
    logic [CNT_WIDTH-1:0] r_stall_count;

    logic w_s1_exe;
    logic w_s1_mem;
    logic w_s2_exe;
    logic w_s2_mem;
    logic w_stall_only;
    logic w_load_use;
    logic w_stall;
    logic w_bubble;

    assign w_s1_exe = id_has_src1 & r_exe_wb_en & (r_exe_dest == id_src1);
    assign w_s1_mem = id_has_src1 & r_mem_wb_en & (r_mem_dest == id_src1);
    assign w_s2_exe = id_has_src2 & r_exe_wb_en & (r_exe_dest == id_src2);
    assign w_s2_mem = id_has_src2 & r_mem_wb_en & (r_mem_dest == id_src2);

    // WB is never checked: the register file writes before ID reads.
    assign w_stall_only = w_s1_exe | w_s1_mem | w_s2_exe | w_s2_mem;
    assign w_load_use   = r_exe_mem_r_en & (w_s1_exe | w_s2_exe);
    assign w_stall      = ~flush &
                          (forwarding_en ? w_load_use : w_stall_only);
    assign w_bubble     = flush | w_stall;

    assign hazard_stall = w_stall;
    assign stall_count  = r_stall_count;

    logic w_f1_mem;
    logic w_f1_wb;
    logic w_f2_mem;
    logic w_f2_wb;

    // Loads in MEM are never forwarded; load-use stall covers them.
    assign w_f1_mem = r_exe_has_src1 & r_mem_wb_en & ~r_mem_mem_r_en &
                      (r_mem_dest == r_exe_src1);
    assign w_f1_wb  = r_exe_has_src1 & r_wb_wb_en &
                      (r_wb_dest == r_exe_src1);
    assign w_f2_mem = r_exe_has_src2 & r_mem_wb_en & ~r_mem_mem_r_en &
                      (r_mem_dest == r_exe_src2);
    assign w_f2_wb  = r_exe_has_src2 & r_wb_wb_en &
                      (r_wb_dest == r_exe_src2);

    always_comb begin
        sel_src1 = 2'b00;
        sel_src2 = 2'b00;
        if (forwarding_en) begin
            if (w_f1_mem)     sel_src1 = 2'b01;
            else if (w_f1_wb) sel_src1 = 2'b10;
            if (w_f2_mem)     sel_src2 = 2'b01;
            else if (w_f2_wb) sel_src2 = 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exe_wb_en    <= 1'b0;
            r_exe_mem_r_en <= 1'b0;
            r_exe_dest     <= 4'd0;
            r_exe_src1     <= 4'd0;
            r_exe_src2     <= 4'd0;
            r_exe_has_src1 <= 1'b0;
            r_exe_has_src2 <= 1'b0;
            r_mem_wb_en    <= 1'b0;
            r_mem_mem_r_en <= 1'b0;
            r_mem_dest     <= 4'd0;
            r_wb_wb_en     <= 1'b0;
            r_wb_dest      <= 4'd0;
            r_stall_count  <= '0;
        end else begin
            r_wb_wb_en     <= r_mem_wb_en;
            r_wb_dest      <= r_mem_dest;
            r_mem_wb_en    <= r_exe_wb_en;
            r_mem_mem_r_en <= r_exe_mem_r_en;
            r_mem_dest     <= r_exe_dest;
            if (w_bubble) begin
                r_exe_wb_en    <= 1'b0;
                r_exe_mem_r_en <= 1'b0;
                r_exe_dest     <= 4'd0;
                r_exe_src1     <= 4'd0;
                r_exe_src2     <= 4'd0;
                r_exe_has_src1 <= 1'b0;
                r_exe_has_src2 <= 1'b0;
            end else begin
                r_exe_wb_en    <= id_wb_en;
                r_exe_mem_r_en <= id_mem_r_en;
                r_exe_dest     <= id_wb_reg_dest;
                r_exe_src1     <= id_src1;
                r_exe_src2     <= id_src2;
                r_exe_has_src1 <= id_has_src1;
                r_exe_has_src2 <= id_has_src2;
            end
            if (w_stall && (r_stall_count != {CNT_WIDTH{1'b1}}))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed scenarios plus random traffic
// checked against an instruction-level pipeline model.
module tb_hazard_forward_unit;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          forwarding_en = 1'b0;
    logic          flush = 1'b0;
    logic [3:0]    id_src1 = 4'd0;
    logic [3:0]    id_src2 = 4'd0;
    logic          id_has_src1 = 1'b0;
    logic          id_has_src2 = 1'b0;
    logic          id_wb_en = 1'b0;
    logic          id_mem_r_en = 1'b0;
    logic [3:0]    id_wb_reg_dest = 4'd0;
    logic          hazard_stall;
    logic [1:0]    sel_src1;
    logic [1:0]    sel_src2;
    logic [CW-1:0] stall_count;

    always #5 clk = ~clk;

    hazard_forward_unit #(.CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .forwarding_en  (forwarding_en),
        .flush          (flush),
        .id_src1        (id_src1),
        .id_src2        (id_src2),
        .id_has_src1    (id_has_src1),
        .id_has_src2    (id_has_src2),
        .id_wb_en       (id_wb_en),
        .id_mem_r_en    (id_mem_r_en),
        .id_wb_reg_dest (id_wb_reg_dest),
        .hazard_stall   (hazard_stall),
        .sel_src1       (sel_src1),
        .sel_src2       (sel_src2),
        .stall_count    (stall_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Instruction-level model: pipe[0]=EXE, pipe[1]=MEM, pipe[2]=WB.
    typedef struct {
        bit wb;
        bit ld;
        int dest;
        int s1;
        int s2;
        bit h1;
        bit h2;
    } ins_t;

    ins_t pipe[3];
    int   m_cnt;

    function automatic ins_t nop();
        ins_t x;
        x = '{wb: 0, ld: 0, dest: 0, s1: 0, s2: 0, h1: 0, h2: 0};
        return x;
    endfunction

    function automatic ins_t cur_id();
        ins_t x;
        x.wb = id_wb_en;
        x.ld = id_mem_r_en;
        x.dest = int'(id_wb_reg_dest);
        x.s1 = int'(id_src1);
        x.s2 = int'(id_src2);
        x.h1 = id_has_src1;
        x.h2 = id_has_src2;
        return x;
    endfunction

    function automatic bit writes(ins_t x, int tag);
        return x.wb && (x.dest == tag);
    endfunction

    function automatic bit blocked(int tag);
        if (forwarding_en)
            return pipe[0].ld && writes(pipe[0], tag);
        return writes(pipe[0], tag) || writes(pipe[1], tag);
    endfunction

    function automatic bit m_stall();
        ins_t id;
        bit   st;
        id = cur_id();
        st = (id.h1 && blocked(id.s1)) || (id.h2 && blocked(id.s2));
        return st && !flush;
    endfunction

    function automatic int m_sel(int k);
        bit h;
        int s;
        h = (k == 1) ? pipe[0].h1 : pipe[0].h2;
        s = (k == 1) ? pipe[0].s1 : pipe[0].s2;
        if (!forwarding_en || !h) return 0;
        if (writes(pipe[1], s) && !pipe[1].ld) return 1;
        if (writes(pipe[2], s)) return 2;
        return 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) pipe[i] = nop();
        m_cnt = 0;
    endtask

    task automatic set_id(input bit wb, input bit ld, input int dest,
                          input bit h1, input int s1,
                          input bit h2, input int s2);
        id_wb_en       = wb;
        id_mem_r_en    = ld;
        id_wb_reg_dest = 4'(dest);
        id_has_src1    = h1;
        id_src1        = 4'(s1);
        id_has_src2    = h2;
        id_src2        = 4'(s2);
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic tick(input string tag);
        bit   st;
        ins_t nxt;
        #1;
        st = m_stall();
        chk({tag, ".stall"}, hazard_stall, st);
        chk({tag, ".sel1"}, sel_src1, m_sel(1));
        chk({tag, ".sel2"}, sel_src2, m_sel(2));
        chk({tag, ".cnt"}, stall_count, m_cnt);
        nxt = (st || flush) ? nop() : cur_id();
        @(posedge clk);
        if (st && m_cnt < CMAX) m_cnt++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nxt;
        @(negedge clk);
    endtask

    function automatic int rtag();
        if ($urandom_range(0, 7) == 0) return 15;
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        m_reset();
        // reset held with random ID traffic
        for (int i = 0; i < 4; i++) begin
            forwarding_en = 1'($urandom);
            set_id(1'($urandom), 1'($urandom), rtag(), 1'($urandom),
                   rtag(), 1'($urandom), rtag());
            @(posedge clk);
            #2;
            chk("rst.stall", hazard_stall, 0);
            chk("rst.sel1", sel_src1, 0);
            chk("rst.sel2", sel_src2, 0);
            chk("rst.cnt", stall_count, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        forwarding_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(0, 0, rtag(), 1, rtag(), 1, rtag());
            tick("idle");
            chk("idle.stall0", hazard_stall, 0);
        end

        // ADD R2 then SUB R2 back to back -> MEM forward
        set_id(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick("fl");
        set_id(1, 0, 2, 1, 7, 0, 0);
        tick("add2");
        set_id(1, 0, 5, 1, 2, 0, 0);
        #1 chk("t2.nostall", hazard_stall, 0);
        tick("sub2");
        set_id(0, 0, 0, 0, 0, 0, 0);
        #1 chk("t2.sel01", sel_src1, 1);
        tick("t2a");
        repeat (3) tick("fl");
        // one unrelated instruction between -> WB forward
        set_id(1, 0, 2, 0, 0, 0, 0);
        tick("add2b");
        set_id(1, 0, 9, 1, 8, 0, 0);
        tick("gap");
        set_id(1, 0, 5, 1, 2, 1, 2);
        tick("sub2b");
        set_id(0, 0, 0, 0, 0, 0, 0);
        #1 chk("t2.sel10", sel_src1, 2);
        chk("t2.same", sel_src2, 2);
        tick("t2b");
        repeat (3) tick("fl");

        // load-use: exactly one stall, then WB forward
        set_id(1, 1, 3, 0, 0, 0, 0);
        tick("ldr3");
        set_id(1, 0, 6, 0, 0, 1, 3);
        #1 chk("t3.stall1", hazard_stall, 1);
        tick("lu1");
        #1 chk("t3.stall0", hazard_stall, 0);
        chk("t3.cnt1", stall_count, 1);
        tick("lu2");
        set_id(0, 0, 0, 0, 0, 0, 0);
        #1 chk("t3.sel10", sel_src2, 2);
        tick("t3");
        repeat (3) tick("fl");

        // stall-only mode: two stall cycles, no forwarding
        forwarding_en = 1'b0;
        set_id(1, 0, 4, 0, 0, 0, 0);
        tick("add4");
        set_id(1, 0, 8, 1, 4, 0, 0);
        #1 chk("t4.s1", hazard_stall, 1);
        tick("orr1");
        #1 chk("t4.s2", hazard_stall, 1);
        tick("orr2");
        #1 chk("t4.s3", hazard_stall, 0);
        chk("t4.cnt3", stall_count, 3);
        tick("orr3");
        set_id(0, 0, 0, 0, 0, 0, 0);
        #1 chk("t4.sel", {sel_src1, sel_src2}, 0);
        tick("t4");
        repeat (3) tick("fl");

        // flush masks a load-use stall
        forwarding_en = 1'b1;
        set_id(1, 1, 6, 0, 0, 0, 0);
        tick("ldr6");
        set_id(1, 0, 1, 1, 6, 1, 6);
        flush = 1'b1;
        #1 chk("t5.nostall", hazard_stall, 0);
        tick("t5f");
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        #1 chk("t5.sel", {sel_src1, sel_src2}, 0);
        chk("t5.cnt", stall_count, 3);
        tick("t5");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) forwarding_en = ~forwarding_en;
            flush = ($urandom_range(0, 7) == 0);
            set_id(1'($urandom), ($urandom_range(0, 2) == 0), rtag(),
                   1'($urandom), rtag(), 1'($urandom), rtag());
            tick("rnd");
        end
        flush = 1'b0;

        // saturation after 20 stall-only cycles, then reset mid-stall
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        forwarding_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_id(1, 0, 1, 0, 0, 0, 0);
            tick("sat.p");
            set_id(1, 0, 7, 1, 1, 0, 0);
            repeat (3) tick("sat.c");
        end
        chk("t6.sat", stall_count, CMAX);
        set_id(1, 0, 1, 0, 0, 0, 0);
        tick("sat.p2");
        set_id(1, 0, 7, 1, 1, 0, 0);
        #1 chk("t6.pre", hazard_stall, 1);
        rst = 1'b1;
        #1 chk("t6.rst.stall", hazard_stall, 0);
        chk("t6.rst.cnt", stall_count, 0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
